// File: rtl/uart_receptor_pkg.sv
// Shared UART definitions: one-hot receiver/transmitter states, oversampling
// constants and default frame format.
package uart_receptor_pkg;

   localparam int D_BIT_DEF  = 8;
   localparam int SB_BIT_DEF = 1;
   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 7;

   localparam logic [3:0] S_MID  = 4'(MID_SAMPLE);
   localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);

   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      START = 4'b0010,
      DATA  = 4'b0100,
      STOP  = 4'b1000
   } rx_state_t;

endpackage

// File: rtl/uart_receptor_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value is a
// parameter so idle-high lines do not see a false edge out of reset.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_receptor.sv
// 16x oversampling UART receiver: start-bit validation at mid-bit, LSB-first
// data capture, stop-bit framing check and a one-clk rx_done strobe.
module uart_receptor
   import uart_receptor_pkg::*;
#(
   parameter int D_BIT  = D_BIT_DEF,
   parameter int SB_BIT = SB_BIT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx,
   input  logic             s_tick,
   output logic [D_BIT-1:0] d_out,
   output logic             rx_done,
   output logic             frame_err,
   output rx_state_t        dbg_state
);

   localparam logic [2:0] N_LAST = 3'(D_BIT - 1);
   localparam logic [1:0] C_LAST = 2'(SB_BIT - 1);

   logic w_rx_s;

   rx_state_t        r_state, w_state_nx;
   logic [3:0]       r_s, w_s_nx;
   logic [2:0]       r_n, w_n_nx;
   logic [1:0]       r_c, w_c_nx;
   logic [D_BIT-1:0] r_shreg, w_shreg_nx;
   logic             r_err, w_err_nx;
   logic [D_BIT-1:0] r_dout, w_dout_nx;
   logic             r_ferr, w_ferr_nx;
   logic             r_done, w_done_nx;

   sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
      .i_clk (clk),
      .i_rst (reset),
      .i_d   (rx),
      .o_q   (w_rx_s)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_s     <= '0;
         r_n     <= '0;
         r_c     <= '0;
         r_shreg <= '0;
         r_err   <= 1'b0;
         r_dout  <= '0;
         r_ferr  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_s     <= w_s_nx;
         r_n     <= w_n_nx;
         r_c     <= w_c_nx;
         r_shreg <= w_shreg_nx;
         r_err   <= w_err_nx;
         r_dout  <= w_dout_nx;
         r_ferr  <= w_ferr_nx;
         r_done  <= w_done_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_s_nx     = r_s;
      w_n_nx     = r_n;
      w_c_nx     = r_c;
      w_shreg_nx = r_shreg;
      w_err_nx   = r_err;
      w_dout_nx  = r_dout;
      w_ferr_nx  = r_ferr;
      w_done_nx  = 1'b0;

      if (s_tick) begin
         case (r_state)
            IDLE: begin
               if (!w_rx_s) begin
                  w_state_nx = START;
                  w_s_nx     = '0;
               end
            end
            START: begin
               // A start bit that is high again at mid-bit was only a glitch.
               if (r_s == S_MID) begin
                  if (!w_rx_s) begin
                     w_state_nx = DATA;
                     w_s_nx     = '0;
                     w_n_nx     = '0;
                  end else begin
                     w_state_nx = IDLE;
                  end
               end else begin
                  w_s_nx = r_s + 4'd1;
               end
            end
            DATA: begin
               if (r_s == S_LAST) begin
                  w_s_nx     = '0;
                  w_shreg_nx = {w_rx_s, r_shreg[D_BIT-1:1]};
                  if (r_n == N_LAST) begin
                     w_state_nx = STOP;
                     w_c_nx     = '0;
                     w_err_nx   = 1'b0;
                  end else begin
                     w_n_nx = r_n + 3'd1;
                  end
               end else begin
                  w_s_nx = r_s + 4'd1;
               end
            end
            STOP: begin
               // Leaving at mid stop bit lets an immediate next start edge be caught.
               if (r_s == S_LAST) begin
                  w_s_nx   = '0;
                  w_err_nx = r_err | ~w_rx_s;
                  if (r_c == C_LAST) begin
                     w_dout_nx  = r_shreg;
                     w_ferr_nx  = r_err | ~w_rx_s;
                     w_done_nx  = 1'b1;
                     w_state_nx = IDLE;
                  end else begin
                     w_c_nx = r_c + 2'd1;
                  end
               end else begin
                  w_s_nx = r_s + 4'd1;
               end
            end
            default: begin
               w_state_nx = IDLE;
               w_s_nx     = '0;
            end
         endcase
      end
   end

   assign d_out     = r_dout;
   assign rx_done   = r_done;
   assign frame_err = r_ferr;
   assign dbg_state = r_state;

endmodule

// File: doc/uart_receptor.md
Name: uart_receptor

Overview:
- UART receiver and companion to the existing UART transmitter. It shares the same 16x oversampling tick (s_tick) and the same D_BIT/SB_BIT framing.
- Deserialises an asynchronous LSB-first line (start bit, D_BIT data bits, SB_BIT stop bits) into a parallel byte.
- Flags framing errors.
- Feeds the processor-side UART interface / debug unit.

Parameters:
- D_BIT, 8, number of data bits per frame (legal range 5..8).
- SB_BIT, 1, number of stop bits (legal values 1 or 2).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; asynchronous to clk; idle level 1.
- s_tick  input  1  oversampling enable, 16 pulses per bit period, one clk wide.
- d_out  output  D_BIT  last received data word.
- rx_done  output  1  one-clk pulse when a frame completes.
- frame_err  output  1  status of the last completed frame; 1 = a stop bit was sampled low.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; s, n, c, shift register, error accumulator all 0.
  - Synchroniser flops = 1.
  - d_out=0, rx_done=0, frame_err=0.
  - Reset mid-frame aborts the frame; no rx_done is produced for it.
- Input path: rx passes through a 2-flop synchroniser (rx_s) before any use. This adds 2 clk of latency and is unconditioned by s_tick.
- FSM advances only on clk edges where s_tick=1. With s_tick=0, state and counters hold.
- rx_done is 0 on every cycle except the single cycle described under STOP.
- Counters:
  - s: 4-bit tick counter, wraps naturally 15->0.
  - n: 3-bit data-bit counter.
  - c: 2-bit stop-bit counter.
- States use one-hot encoding: IDLE, START, DATA, STOP.
- IDLE:
  - If rx_s=0: go to START with s=0.
  - Otherwise stay in IDLE.
- START:
  - If s=7 (mid start bit): if rx_s=0, go to DATA with s=0, n=0. If rx_s=1, the start is false (glitch): go to IDLE with no output change.
  - Otherwise s=s+1.
- DATA:
  - If s=15: shift register = {rx_s, shreg[D_BIT-1:1]} (LSB first), then s=0.
  - If n=D_BIT-1, go to STOP with c=0 and error accumulator=0. Otherwise n=n+1.
  - Otherwise s=s+1.
- STOP:
  - If s=15: s=0 and error accumulator |= ~rx_s.
  - If c=SB_BIT-1 (last stop bit):
    - d_out <= shift register;
    - frame_err <= accumulator | ~rx_s;
    - rx_done <= 1 for exactly one clk;
    - go to IDLE.
  - Otherwise (s=15, not the last stop bit) c=c+1.
  - Otherwise s=s+1.
- Timing:
  - Counting the IDLE tick that sees rx_s=0 as tick 0, the start bit is checked at tick 8.
  - Data bit i is sampled at tick 8+16(i+1).
  - The last stop bit is sampled at tick 8+16(D_BIT+SB_BIT): tick 152 for 8N1.
  - rx_done is high in the clk cycle after that tick's edge.
- Framing error: the frame is still delivered. rx_done=1, d_out is updated, frame_err=1. There is no resynchronisation hunt; the receiver returns to IDLE and waits for rx_s=0.
- Hold rules:
  - d_out and frame_err hold between completed frames.
  - They change only in the rx_done cycle.
- Back-to-back frames: returning to IDLE mid stop bit allows a start edge immediately following the stop bit to be caught with no lost frame.
- Line held low (break): a frame of all zeros with frame_err=1. The receiver then re-enters START on the next tick and repeats while the line stays low.

Decomposition:
- Shared include/package (uart_defs):
  - one-hot state localparams IDLE/START/DATA/STOP;
  - OVERSAMPLE=16 and MID_SAMPLE=7;
  - default D_BIT/SB_BIT.
- The transmitter and receiver use the same package.
- One natural sub-module: sync_2ff, the 1-bit two-flop synchroniser.
  - Async reset to a parameterised value; 1 here.
  - Reusable for other asynchronous inputs.

Test Plan:
- 8N1, s_tick every 4th clk, send 0xA5 (line 0,1,0,1,0,0,1,0,1,1) -> rx_done single-clk pulse, d_out=0xA5, frame_err=0. Pulse occurs ~152 ticks after the falling edge (plus synchroniser delay).
- Glitch: rx low for 5 ticks, then high -> START aborts at tick 8, no rx_done, state back to IDLE, d_out unchanged. A following 0x3C frame is received correctly.
- Framing error: send 0x3C with stop bit driven 0 -> rx_done=1, d_out=0x3C, frame_err=1. Next good frame 0x55 -> frame_err returns to 0.
- Back-to-back 0x00 then 0xFF with no idle gap -> two rx_done pulses, d_out=0x00 then 0xFF, both frame_err=0.
- SB_BIT=2: send 0x81 with the first stop bit 1 and the second 0 -> frame_err=1. Both stop bits 1 -> frame_err=0, d_out=0x81.
- Assert reset mid-DATA of frame 0x5A -> outputs clear immediately (async), no rx_done for the aborted frame. Release reset and send 0xC3 -> d_out=0xC3.
